// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge: UART command port that issues single APB read/write
// transfers. Contains its own 8N1 uart_rx/uart_tx cores; one bit lasts
// cfg_div_i clock cycles, and a new divisor is taken at the start of each byte.
// Optional PREADY timeout: define UART_APB_BRIDGE_TIMEOUT_EN.

module uart_rx (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [15:0] div_i,
  input  logic        rx_i,
  input  logic        rx_ready_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_BITS, S_STOP} rx_state_t;

  rx_state_t   state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] div_q, div_d, timer_q, timer_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, data_q, data_d;
  logic        valid_q, valid_d;

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;

  // Frame decoder: find the start edge, sample each bit at its centre.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready_i;
    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_START;
          div_d   = div_i;
          timer_d = div_i >> 1;
        end
      end
      S_START: begin
        if (timer_q == 16'd0) begin
          if (!sync2_q) begin
            state_d = S_BITS;
            timer_d = div_q - 16'd1;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;   // glitch, not a real start bit
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_BITS: begin
        if (timer_q == 16'd0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          timer_d = div_q - 16'd1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STOP: begin
        if (timer_q == 16'd0) begin
          state_d = S_IDLE;
          if (sync2_q) begin   // bytes with a broken stop bit are discarded
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver state, including the two-stage synchroniser on the serial input.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      div_q   <= 16'd0;
      timer_q <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

module uart_tx (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [15:0] div_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        tx_o
);
  logic        busy_q, busy_d;
  logic [8:0]  frame_q, frame_d;   // data bits then stop bit, shifted out LSB first
  logic [3:0]  bits_q, bits_d;
  logic [15:0] div_q, div_d, timer_q, timer_d;
  logic        tx_q, tx_d;

  assign tx_ready_o = ~busy_q;
  assign tx_o       = tx_q;

  // Serialiser: start bit on accept, then one bit every div cycles.
  always_comb begin
    busy_d  = busy_q;
    frame_d = frame_q;
    bits_d  = bits_q;
    div_d   = div_q;
    timer_d = timer_q;
    tx_d    = tx_q;
    if (!busy_q) begin
      if (tx_valid_i) begin
        busy_d  = 1'b1;
        tx_d    = 1'b0;
        frame_d = {1'b1, tx_data_i};
        bits_d  = 4'd9;
        div_d   = div_i;
        timer_d = div_i - 16'd1;
      end
    end else if (timer_q != 16'd0) begin
      timer_d = timer_q - 16'd1;
    end else if (bits_q == 4'd0) begin
      busy_d = 1'b0;
      tx_d   = 1'b1;
    end else begin
      tx_d    = frame_q[0];
      frame_d = {1'b1, frame_q[8:1]};
      bits_d  = bits_q - 4'd1;
      timer_d = div_q - 16'd1;
    end
  end

  // Transmitter state; the line idles high.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      busy_q  <= 1'b0;
      frame_q <= 9'h1FF;
      bits_q  <= 4'd0;
      div_q   <= 16'd0;
      timer_q <= 16'd0;
      tx_q    <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      frame_q <= frame_d;
      bits_q  <= bits_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      tx_q    <= tx_d;
    end
  end
endmodule

module uart_apb_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [15:0]               cfg_div_i,
  input  logic                      rx_i,
  output logic                      tx_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy_o
);
  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, APB_SETUP, APB_ACCESS, TX_STATUS, TX_DATA
  } state_t;

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic [7:0]  status_q, status_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LAST;
`endif

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_fire;

  uart_rx u_rx (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .div_i      (cfg_div_i),
    .rx_i       (rx_i),
    .rx_ready_i (1'b1),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid)
  );

  uart_tx u_tx (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .div_i      (cfg_div_i),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .tx_o       (tx_o)
  );

  // The response byte on offer follows directly from the state and byte count.
  assign tx_valid = (state_q == TX_STATUS) || (state_q == TX_DATA);
  assign tx_data  = (state_q == TX_STATUS) ? status_q : rdata_q[8*cnt_q +: 8];
  assign tx_fire  = tx_valid & tx_ready;

  assign PADDR   = addr_q[APB_ADDR_WIDTH-1:0];
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign busy_o  = (state_q != IDLE);

  // Command parser, single APB transfer and response sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    status_d  = status_q;
    rdata_d   = rdata_q;
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            pwrite_d = (rx_data == 8'h57);
            cnt_d    = 2'd0;
            state_d  = RX_ADDR;
          end else begin
            status_d = 8'hEE;
            state_d  = TX_STATUS;
          end
        end
      end
      RX_ADDR: begin
        if (rx_valid) begin
          addr_d[8*cnt_q +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (pwrite_q) begin
              cnt_d   = 2'd0;
              state_d = RX_DATA;
            end else begin
              psel_d  = 1'b1;
              state_d = APB_SETUP;
            end
          end
        end
      end
      RX_DATA: begin
        if (rx_valid) begin
          pwdata_d[8*cnt_q +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            psel_d  = 1'b1;
            state_d = APB_SETUP;
          end
        end
      end
      APB_SETUP: begin
        penable_d = 1'b1;
        state_d   = APB_ACCESS;
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
      end
      APB_ACCESS: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (!pwrite_q) rdata_d = PRDATA;
          status_d  = PSLVERR ? 8'h01 : 8'h00;
          state_d   = TX_STATUS;
        end
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (!pwrite_q) rdata_d = 32'hDEADBEEF;
          status_d  = 8'h02;
          state_d   = TX_STATUS;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      TX_STATUS: begin
        if (tx_fire) begin
          // Only a real read (never a rejected command) carries data bytes.
          if (!pwrite_q && status_q != 8'hEE) begin
            cnt_d   = 2'd0;
            state_d = TX_DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TX_DATA: begin
        if (tx_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bridge state and registered APB outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= 32'd0;
      pwdata_q  <= 32'd0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      status_q  <= 8'd0;
      rdata_q   <= 32'd0;
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_apb_bridge.sv
// tb_uart_apb_bridge: drives framed commands over the serial input, plays an
// APB slave with programmable wait states, decodes the serial responses and
// checks everything against a frame-level model of the bridge.
module tb_uart_apb_bridge;
  localparam int DIV      = 8;
  localparam int TOUT_CYC = 16;
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [15:0] cfg_div_i = 16'(DIV);
  logic        rx_i = 1'b1;
  logic        tx_o;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = 32'd0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  // APB slave behaviour for the current command
  int          sl_waits = 0;
  logic [31:0] sl_rdata = 32'd0;
  logic        sl_err = 1'b0;
  // record of the most recent transfer
  int          xfer_cnt = 0;
  logic [31:0] x_addr = 32'd0, x_wdata = 32'd0;
  logic        x_write = 1'b0;
  int          x_psel = 0, x_pen = 0, acc_k = 0;
  int          proto_errs = 0;
  // decoded response bytes
  logic [7:0]  resp_q[$];
  int          frame_errs = 0;

  uart_apb_bridge #(.APB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TOUT_CYC)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .cfg_div_i (cfg_div_i),
    .rx_i      (rx_i),
    .tx_o      (tx_o),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .busy_o    (busy_o)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // APB slave: inputs set at negedge take effect at the following posedge.
  initial begin
    forever begin
      @(negedge CLK);
      if (PSEL && !PENABLE) begin
        xfer_cnt++;
        x_addr  = PADDR;
        x_wdata = PWDATA;
        x_write = PWRITE;
        x_psel  = 1;
        x_pen   = 0;
        acc_k   = 0;
        PREADY  = ($urandom & 1) != 0;
        PRDATA  = $urandom;
        PSLVERR = ($urandom & 1) != 0;
      end else if (PSEL && PENABLE) begin
        x_psel++;
        x_pen++;
        acc_k++;
        if (PADDR !== x_addr || PWDATA !== x_wdata || PWRITE !== x_write) proto_errs++;
        if (acc_k > sl_waits) begin
          PREADY  = 1'b1;
          PRDATA  = sl_rdata;
          PSLVERR = sl_err;
        end else begin
          PREADY  = 1'b0;
          PRDATA  = $urandom;
          PSLVERR = ($urandom & 1) != 0;
        end
      end else begin
        if (PENABLE) proto_errs++;
        PREADY  = ($urandom & 1) != 0;
        PRDATA  = $urandom;
        PSLVERR = ($urandom & 1) != 0;
      end
    end
  end

  // Serial response decoder, sampling mid-bit on negedges.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge CLK);
      if (RSTN && tx_o === 1'b0) begin
        repeat (DIV / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge CLK);
          b[i] = tx_o;
        end
        repeat (DIV) @(negedge CLK);
        if (tx_o !== 1'b1) frame_errs++;
        resp_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = fr[i];
      repeat (DIV) @(negedge CLK);
    end
    repeat (gap * DIV) @(negedge CLK);
  endtask

  task automatic wait_resp(input int n);
    int budget;
    budget = 0;
    while (resp_q.size() < n && budget < 20000) begin
      @(negedge CLK);
      budget++;
    end
  endtask

  // One full command: the model predicts the response bytes and the transfer.
  task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] rd, input logic err);
    logic [7:0]  exp_q[$];
    logic [7:0]  st;
    logic [31:0] rd_exp;
    bit          valid, is_wr, timed_out;
    int          x0, pen_exp, n;
    valid     = (cmd == 8'h57) || (cmd == 8'h52);
    is_wr     = (cmd == 8'h57);
    timed_out = TOUT_EN && (waits >= TOUT_CYC);
    pen_exp   = timed_out ? TOUT_CYC : waits + 1;
    rd_exp    = timed_out ? 32'hDEADBEEF : rd;
    st        = !valid ? 8'hEE : (timed_out ? 8'h02 : (err ? 8'h01 : 8'h00));
    exp_q.push_back(st);
    if (valid && !is_wr)
      for (int i = 0; i < 4; i++) exp_q.push_back(rd_exp[8*i +: 8]);

    sl_waits = waits;
    sl_rdata = rd;
    sl_err   = err;
    resp_q.delete();
    x0 = xfer_cnt;

    send_byte(cmd, $urandom_range(0, 2));
    if (valid) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], $urandom_range(0, 2));
      if (is_wr)
        for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8], $urandom_range(0, 2));
    end

    wait_resp(exp_q.size());
    chk({tag, "_resp_count"}, 32'(resp_q.size()), 32'(exp_q.size()));
    n = (resp_q.size() < exp_q.size()) ? resp_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(resp_q[i]), 32'(exp_q[i]));
    repeat (12 * DIV) @(negedge CLK);
    chk({tag, "_no_extra_bytes"}, 32'(resp_q.size()), 32'(exp_q.size()));
    chk({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    chk({tag, "_psel_after"}, 32'(PSEL), 32'd0);
    if (valid) begin
      chk({tag, "_xfers"}, 32'(xfer_cnt - x0), 32'd1);
      chk({tag, "_paddr"}, x_addr, addr);
      chk({tag, "_pwrite"}, 32'(x_write), 32'(is_wr));
      if (is_wr) chk({tag, "_pwdata"}, x_wdata, wdata);
      chk({tag, "_psel_cycles"}, 32'(x_psel), 32'(pen_exp + 1));
      chk({tag, "_penable_cycles"}, 32'(x_pen), 32'(pen_exp));
      chk({tag, "_paddr_held"}, PADDR, addr);
      chk({tag, "_pwrite_held"}, 32'(PWRITE), 32'(is_wr));
    end else begin
      chk({tag, "_xfers"}, 32'(xfer_cnt - x0), 32'd0);
    end
    $display("cmd %s: op=%02h addr=%08h resp_bytes=%0d", tag, cmd, addr, resp_q.size());
  endtask

  initial begin
    logic [7:0]  c;
    int          budget, x0;
    // reset values
    repeat (3) @(negedge CLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_tx", 32'(tx_o), 32'd1);
    RSTN = 1'b1;
    repeat (4 * DIV) @(negedge CLK);

    run_cmd("write", 8'h57, 32'h1A001000, 32'h12345678, 0, 32'h0, 1'b0);
    run_cmd("read_wait", 8'h52, 32'h00000004, 32'h0, 5, 32'hCAFEF00D, 1'b0);
    run_cmd("read_slverr", 8'h52, 32'h00000010, 32'h0, 2, 32'h00000000, 1'b1);
    run_cmd("write_slverr", 8'h57, 32'h40000020, 32'hA5A55A5A, 1, 32'h0, 1'b1);
    run_cmd("bad_cmd", 8'h41, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    run_cmd("after_bad", 8'h57, 32'h00C0FFEE, 32'h87654321, 3, 32'h0, 1'b0);

    // asynchronous reset during the access phase of a read
    sl_waits = 40;
    sl_rdata = 32'h11223344;
    sl_err   = 1'b0;
    resp_q.delete();
    x0 = xfer_cnt;
    send_byte(8'h52, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 0);
    budget = 0;
    while (!(PSEL && PENABLE) && budget < 2000) begin
      @(negedge CLK);
      budget++;
    end
    chk("rst_mid_reached_access", 32'({PSEL, PENABLE}), 32'd3);
    #2 RSTN = 1'b0;
    #1;
    chk("rst_mid_psel", 32'(PSEL), 32'd0);
    chk("rst_mid_penable", 32'(PENABLE), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_tx", 32'(tx_o), 32'd1);
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    repeat (60 * DIV) @(negedge CLK);
    chk("rst_mid_no_resp", 32'(resp_q.size()), 32'd0);
    chk("rst_mid_xfers", 32'(xfer_cnt - x0), 32'd1);
    $display("cmd rst_mid: reset during access, resp_bytes=%0d", resp_q.size());
    run_cmd("after_reset", 8'h52, 32'h0BADF00D, 32'h0, 4, 32'h5EED5EED, 1'b0);

`ifdef UART_APB_BRIDGE_TIMEOUT_EN
    run_cmd("limit_ready_wins", 8'h52, 32'h00001234, 32'h0, TOUT_CYC - 1, 32'h76543210, 1'b0);
    run_cmd("timeout_read", 8'h52, 32'h00005678, 32'h0, 100000, 32'h0, 1'b0);
    run_cmd("timeout_write", 8'h57, 32'h00009ABC, 32'h13572468, 100000, 32'h0, 1'b0);
`endif

    // randomized commands
    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 4))
        0, 1:    c = 8'h57;
        2, 3:    c = 8'h52;
        default: begin
          c = 8'($urandom);
          if (c == 8'h57 || c == 8'h52) c = 8'h00;
        end
      endcase
      run_cmd($sformatf("rand%0d", k), c, $urandom, $urandom, $urandom_range(0, 7),
              $urandom, ($urandom_range(0, 3) == 0));
    end

    chk("apb_protocol", 32'(proto_errs), 32'd0);
    chk("uart_framing", 32'(frame_errs), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_apb_bridge.md
Name: uart_apb_bridge

Overview:
- UART-driven APB initiator used as a debug/boot access port: the host sends framed commands over a serial line, and the block issues single APB read/write transfers to the SoC peripheral bus.
- It is the requesting end of the APB interface that the peripheral UART serves.
- Uses the codebase's uart_rx/uart_tx cores internally: 8 data bits, no parity, 1 stop bit, divisor from cfg_div_i.
- Sits at SoC top next to the JTAG debug path; drives one APB master port into the peripheral interconnect.

Parameters:
- APB_ADDR_WIDTH, 32, width of PADDR; the received 32-bit address is truncated to the low APB_ADDR_WIDTH bits.
- TIMEOUT_CYCLES, 1024, PREADY wait limit (used only with the optional feature).

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- cfg_div_i  in  16  baud divisor passed to uart_rx/uart_tx
- rx_i  in  1  serial command input
- tx_o  out  1  serial response output
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error
- busy_o  out  1  high while in any state other than IDLE

Behaviour:
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy_o=0, tx_o=1 (idle line). FSM goes to IDLE; byte counter and response registers are cleared.
- Command frame (host to bridge):
  - CMD byte: 0x57 ('W') = write, 0x52 ('R') = read.
  - ADDR: 4 bytes, LSB first.
  - Write only: DATA, 4 bytes, LSB first.
- Response frame (bridge to host):
  - STATUS byte: 0x00 = OK, 0x01 = PSLVERR, 0x02 = timeout, 0xEE = bad command.
  - Read only: 4 PRDATA bytes, LSB first, sent even when status is non-zero (captured value).
- Receive path: uart_rx rx_ready_i is tied high in all states; bytes arriving outside IDLE/RX_ADDR/RX_DATA are dropped.
- Transmit path: each byte is presented on uart_tx tx_data_i with tx_valid_i=1 and held until tx_ready_o; advance on the valid&ready cycle.
- FSM:
  - IDLE: on an rx byte, 0x57/0x52 latches PWRITE, clears cnt, goes to RX_ADDR; any other byte loads status 0xEE and goes to TX_STATUS.
  - RX_ADDR: shifts the byte into addr[8*cnt+:8]; after cnt==3 goes to RX_DATA (write) or APB_SETUP (read).
  - RX_DATA: same scheme into PWDATA; after cnt==3 goes to APB_SETUP.
  - APB_SETUP: PSEL=1, PENABLE=0 for exactly 1 cycle; PADDR/PWDATA/PWRITE are stable; goes to APB_ACCESS.
  - APB_ACCESS: PSEL=1, PENABLE=1 until the cycle PREADY=1. In that cycle capture PRDATA (read), set status = PSLVERR ? 0x01 : 0x00, then deassert PSEL/PENABLE next cycle and go to TX_STATUS.
  - TX_STATUS: sends status; read goes to TX_DATA with cnt=0, write (or bad command) goes to IDLE.
  - TX_DATA: sends rdata[8*cnt+:8]; after cnt==3 goes to IDLE.
- APB timing: minimum transfer is 2 cycles (SETUP + ACCESS with PREADY=1). PADDR, PWDATA and PWRITE hold their values after the transfer until the next command loads them.
- cnt: 2-bit, wraps 3 to 0; always cleared on entry to RX_ADDR, RX_DATA and TX_DATA.
- No back-to-back APB transfers: one command produces exactly one transfer.
- busy_o is combinational from the state register.
- cfg_div_i changes take effect at the next uart byte boundary; the bridge does not synchronise them.

Optional Feature:
- Macro UART_APB_BRIDGE_TIMEOUT_EN.
  - Defined: a counter clears on entry to APB_ACCESS and increments each cycle PREADY=0. When it reaches TIMEOUT_CYCLES-1 with PREADY still 0, the next cycle deasserts PSEL/PENABLE, sets status=0x02, sets rdata=0xDEADBEEF (read) and goes to TX_STATUS. A PREADY=1 arriving in the same cycle as the limit wins (normal completion).
  - Not defined: the counter logic is absent and APB_ACCESS waits indefinitely for PREADY. Status 0x02 is never produced.

Test Plan:
- Write: rx bytes 57 00 10 00 1A 78 56 34 12 with PREADY=1 -> one APB write with PADDR=0x1A001000, PWDATA=0x12345678, PSEL high 2 cycles, PENABLE high 1 cycle; tx byte 00.
- Read with wait states: rx 52 04 00 00 00, PREADY low 5 cycles then high with PRDATA=0xCAFEF00D -> PENABLE high 6 cycles; tx 00 0D F0 FE CA.
- Slave error: read with PSLVERR=1, PRDATA=0x0 on the PREADY cycle -> tx 01 00 00 00 00; FSM back in IDLE, busy_o=0.
- Bad command: rx byte 0x41 -> no PSEL assertion; tx EE; a following valid write command executes normally.
- Reset mid-operation: assert RSTN low during APB_ACCESS (PSEL=1, PENABLE=1) -> PSEL, PENABLE and busy_o go to 0 asynchronously, tx_o=1, no response byte sent; the next full command completes correctly.
- With UART_APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16: read with PREADY held 0 -> PSEL drops after 16 ACCESS cycles; tx 02 EF BE AD DE.
